mul_seq_ctrl: RTL and testbench

- Multi-cycle 32x32 multiply sequencer for the CPU multiply path.
- Time-shares one internal pipelined 16x16 unsigned multiplier across four partial products: a_lo*b_lo, a_hi*b_lo, a_lo*b_hi and a_hi*b_hi.
- Accumulates the partial products into a 64-bit product and applies a sign correction for signed ops.
- Returns the result over a valid/ready handshake.
- Replaces the two-multiplier low-word cell in area-constrained builds and adds the high-word ops MULXSS, MULXSU and MULXUU.

---
 rtl/mul_seq_ctrl_if.sv | 23 ++
 rtl/mul_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_mul_seq_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_if.sv
// Request/response handshake bundle for the sequential 32x32 multiplier.
// The master side issues requests and consumes results. The slave side is the multiplier.
interface mul_seq_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [63:0] rsp_product;

    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_product
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_product
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 32x32 multiply sequencer. One pipelined 16x16 multiplier is shared across four
// tagged partial products, which are accumulated into a 64-bit sum and then sign corrected.
module mul_seq_ctrl #(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    mul_seq_ctrl_if.slave bus
);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_XSS = 2'b01;
    localparam logic [1:0] OP_XSU = 2'b10;
    localparam logic [1:0] LAST_DRAIN = 2'(MUL_LATENCY - 1);

    if (MUL_LATENCY < 1 || MUL_LATENCY > 3) begin : gen_bad_latency
        $error("MUL_LATENCY must be in 1..3");
    end

    typedef enum logic [2:0] {StIdle, StIssue, StDrain, StFix, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [1:0]  idx_q, drain_q, last_idx;
    logic [63:0] acc_q, acc_d, addend;
    logic [63:0] product_q, fixed;
    logic [31:0] result_q, hi_fix;
    logic [15:0] a_half, b_half;
    logic [31:0] mul_raw;
    logic        accept, issue;

    logic [31:0]            pipe_prod [MUL_LATENCY];
    logic [1:0]             pipe_tag  [MUL_LATENCY];
    logic [MUL_LATENCY-1:0] pipe_vld;

    assign bus.req_ready   = (state_q == StIdle) & ~reset;
    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.rsp_result  = result_q;
    assign bus.rsp_product = product_q;

    assign accept   = bus.req_valid & bus.req_ready;
    // MUL only needs the low word, so the a_hi*b_hi term is skipped.
    assign last_idx = (op_q == OP_MUL) ? 2'd2 : 2'd3;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: begin
                issue = 1'b1;
                if (idx_q == last_idx) state_d = StDrain;
            end
            StDrain: if (drain_q == LAST_DRAIN) state_d = StFix;
            StFix:   state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Issue index bit 0 picks the src1 half and bit 1 picks the src2 half.
    assign a_half  = idx_q[0] ? a_q[31:16] : a_q[15:0];
    assign b_half  = idx_q[1] ? b_q[31:16] : b_q[15:0];
    assign mul_raw = {16'b0, a_half} * {16'b0, b_half};

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= issue;
            for (int unsigned i = 1; i < MUL_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_prod[0] <= mul_raw;
        pipe_tag[0]  <= idx_q;
        for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
            pipe_prod[i] <= pipe_prod[i-1];
            pipe_tag[i]  <= pipe_tag[i-1];
        end
    end

    always_comb begin
        addend = {32'b0, pipe_prod[MUL_LATENCY-1]};
        unique case (pipe_tag[MUL_LATENCY-1])
            2'd0:       addend = addend;
            2'd1, 2'd2: addend = addend << 16;
            2'd3:       addend = addend << 32;
            default:    addend = addend;
        endcase
        acc_d = acc_q;
        if (accept)                            acc_d = '0;
        else if (pipe_vld[MUL_LATENCY-1])      acc_d = acc_q + addend;
    end

    // Signed fix-up: an operand with its top bit set weighs -2^32 more than unsigned.
    always_comb begin
        hi_fix = acc_q[63:32];
        if ((op_q == OP_XSS || op_q == OP_XSU) && a_q[31]) hi_fix = hi_fix - b_q;
        if (op_q == OP_XSS && b_q[31])                    hi_fix = hi_fix - a_q;
        fixed = {hi_fix, acc_q[31:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            drain_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (accept) begin
                op_q  <= bus.req_op;
                a_q   <= bus.req_src1;
                b_q   <= bus.req_src2;
                idx_q <= '0;
            end else if (issue) begin
                idx_q <= idx_q + 2'd1;
            end
            if (state_q == StDrain) drain_q <= drain_q + 2'd1;
            else                    drain_q <= '0;
            if (state_q == StFix) begin
                product_q <= fixed;
                result_q  <= (op_q == OP_MUL) ? fixed[31:0] : fixed[63:32];
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl, covering one instance at MUL_LATENCY=1 and one at
// MUL_LATENCY=3. Both instances share the stimulus and a select picks which one is observed.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = '0;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic        rsp_ready = 1'b0;
    logic        sel = 1'b0;

    logic        obs_req_ready, obs_rsp_valid;
    logic [31:0] obs_result;
    logic [63:0] obs_product;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl_if bus0 ();
    mul_seq_ctrl_if bus1 ();

    assign bus0.req_valid = req_valid;
    assign bus0.req_op    = req_op;
    assign bus0.req_src1  = req_src1;
    assign bus0.req_src2  = req_src2;
    assign bus0.rsp_ready = rsp_ready;
    assign bus1.req_valid = req_valid;
    assign bus1.req_op    = req_op;
    assign bus1.req_src1  = req_src1;
    assign bus1.req_src2  = req_src2;
    assign bus1.rsp_ready = rsp_ready;

    mul_seq_ctrl #(.MUL_LATENCY(1)) dut_l1 (.clk(clk), .reset(reset), .bus(bus0));
    mul_seq_ctrl #(.MUL_LATENCY(3)) dut_l3 (.clk(clk), .reset(reset), .bus(bus1));

    always_comb begin
        obs_req_ready = sel ? bus1.req_ready   : bus0.req_ready;
        obs_rsp_valid = sel ? bus1.rsp_valid   : bus0.rsp_valid;
        obs_result    = sel ? bus1.rsp_result  : bus0.rsp_result;
        obs_product   = sel ? bus1.rsp_product : bus0.rsp_product;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (L=%0d): got %h expected %h", tag, sel ? 3 : 1, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle and then scramble the inputs to prove they are latched.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        tick();
        req_valid = 1'b0;
        req_op    = ~op;
        req_src1  = ~a;
        req_src2  = ~b;
    endtask

    // Returns the cycle number, counted from the acceptance cycle, in which rsp_valid is seen.
    task automatic wait_rsp(output int n);
        n = 1;
        while (!obs_rsp_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " req_ready after rsp"}, 64'(obs_req_ready), 64'd1);
        check({tag, " rsp_valid after rsp"}, 64'(obs_rsp_valid), 64'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_prod, input logic full,
                       input logic [31:0] exp_res, input int exp_lat);
        int n;
        send(op, a, b);
        wait_rsp(n);
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        if (full) check({tag, " product"}, obs_product, exp_prod);
        else      check({tag, " product lo"}, {32'b0, obs_product[31:0]}, {32'b0, exp_prod[31:0]});
        check({tag, " result"}, {32'b0, obs_result}, {32'b0, exp_res});
        finish_rsp(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        tick();
        check("req_ready in reset", 64'(obs_req_ready), 64'd0);
        tick();
        check("reset rsp_valid", 64'(obs_rsp_valid), 64'd0);
        check("reset rsp_result", {32'b0, obs_result}, 64'd0);
        check("reset rsp_product", obs_product, 64'd0);
        reset = 1'b0;
        #1;
        check("req_ready after reset", 64'(obs_req_ready), 64'd1);
    endtask

    task automatic run_all(input int lx);
        int lm = lx - 1;
        int n;
        do_reset();
        run("xuu max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1,
            32'hFFFF_FFFE, lx);
        run("xss -1*-1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1,
            32'h0000_0000, lx);
        run("xss min*min", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1,
            32'h4000_0000, lx);
        run("xss -2*3", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1,
            32'hFFFF_FFFF, lx);
        run("xsu max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 1'b1,
            32'hFFFF_FFFF, lx);
        run("mul small", 2'b00, 32'h0001_0003, 32'h0002_0005, 64'h0000_0000_000B_000F, 1'b0,
            32'h000B_000F, lm);
        run("mul max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0,
            32'h0000_0001, lm);
        run("xuu zero", 2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0, 1'b1, 32'h0, lx);

        // Backpressure: the response must hold while the consumer stalls.
        send(2'b11, 32'h0001_0000, 32'h0001_0000);
        wait_rsp(n);
        check("bp latency", 64'(n), 64'(lx));
        for (int i = 0; i < 5; i++) begin
            check("bp rsp_valid held", 64'(obs_rsp_valid), 64'd1);
            check("bp result held", {32'b0, obs_result}, 64'd1);
            check("bp product held", obs_product, 64'h0000_0001_0000_0000);
            check("bp req_ready low", 64'(obs_req_ready), 64'd0);
            tick();
        end
        finish_rsp("bp");
        run("bp second", 2'b11, 32'd7, 32'd9, 64'd63, 1'b1, 32'd0, lx);

        // Reset while the last partial products are still draining.
        send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort rsp_valid", 64'(obs_rsp_valid), 64'd0);
        check("abort req_ready", 64'(obs_req_ready), 64'd1);
        run("after abort", 2'b11, 32'd2, 32'd3, 64'd6, 1'b1, 32'd0, lx);
    endtask

    initial begin
        #1;
        sel = 1'b0;
        run_all(7);
        sel = 1'b1;
        run_all(9);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
